// File: rtl/matrix_scan_ctrl.sv
// matrix_scan_ctrl: scan controller for a row-multiplexed LED matrix panel.
// Shifts COLS pixels per row and bit-plane, then blanks, latches and displays.
// Rows advance after all PLANES planes. The scroll offset advances once per frame.
//
// Ports:
//   clk        - sole clock, posedge
//   reset      - asynchronous, active-high
//   enable     - run request, sampled in IDLE and at frame end
//   sclk       - panel shift clock
//   latch      - panel data latch strobe
//   blank      - panel output disable (1 = dark)
//   row_addr   - current scan row
//   col_addr   - column whose pixel data is on the shift bus
//   plane      - current bit-plane
//   offset     - horizontal scroll offset for the pixel source
//   frame_done - one-cycle pulse on the last display cycle of a frame
//
// Build option: define MATRIX_SCAN_BCM_EN for binary-coded modulation.
// With it, DISPLAY lasts DIV*2^plane cycles. Without it, DISPLAY lasts DIV cycles.
//
// All outputs are registered from the current state and counters.
// They therefore trail the internal FSM by one cycle.
module matrix_scan_ctrl #(
  parameter int unsigned COLS   = 32,
  parameter int unsigned ROWS   = 8,
  parameter int unsigned PLANES = 4,
  parameter int unsigned DIV    = 4
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      enable,
  output logic                                      sclk,
  output logic                                      latch,
  output logic                                      blank,
  output logic [$clog2(ROWS)-1:0]                   row_addr,
  output logic [$clog2(COLS)-1:0]                   col_addr,
  output logic [(PLANES > 1 ? $clog2(PLANES) : 1)-1:0] plane,
  output logic [$clog2(COLS)-1:0]                   offset,
  output logic                                      frame_done
);

  localparam int unsigned ROW_W   = $clog2(ROWS);
  localparam int unsigned COL_W   = $clog2(COLS);
  localparam int unsigned PLANE_W = (PLANES > 1) ? $clog2(PLANES) : 1;
`ifdef MATRIX_SCAN_BCM_EN
  localparam int unsigned DISP_MAX = DIV << (PLANES - 1);
`else
  localparam int unsigned DISP_MAX = DIV;
`endif
  localparam int unsigned TICK_W  = (DISP_MAX > 1) ? $clog2(DISP_MAX) : 1;

  typedef enum logic [2:0] {
    IDLE, SHIFT_LO, SHIFT_HI, BLANK, LATCH, DISPLAY
  } state_t;

  state_t               state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [PLANE_W-1:0]   plane_q, plane_d;
  logic [COL_W-1:0]     off_q, off_d;
  logic                 frame_end_c;
  logic                 phase_last_c;
  logic                 disp_last_c;

  // End of a DIV-cycle phase, and end of the display window for the current plane.
  assign phase_last_c = (tick_q == TICK_W'(DIV - 1));
`ifdef MATRIX_SCAN_BCM_EN
  assign disp_last_c  = (tick_q == TICK_W'((DIV << plane_q) - 1));
`else
  assign disp_last_c  = phase_last_c;
`endif

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      plane_q <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      col_q   <= col_d;
      row_q   <= row_d;
      plane_q <= plane_d;
      off_q   <= off_d;
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q + TICK_W'(1);
    col_d       = col_q;
    row_d       = row_q;
    plane_d     = plane_q;
    off_d       = off_q;
    frame_end_c = 1'b0;
    case (state_q)
      IDLE: begin
        tick_d = '0;
        if (enable) state_d = SHIFT_LO;
      end
      SHIFT_LO: begin
        if (phase_last_c) begin
          tick_d  = '0;
          state_d = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (phase_last_c) begin
          tick_d = '0;
          if (col_q == COL_W'(COLS - 1)) begin
            col_d   = '0;
            state_d = BLANK;
          end else begin
            col_d   = col_q + COL_W'(1);
            state_d = SHIFT_LO;
          end
        end
      end
      BLANK: begin
        if (phase_last_c) begin
          tick_d  = '0;
          state_d = LATCH;
        end
      end
      LATCH: begin
        if (phase_last_c) begin
          tick_d  = '0;
          state_d = DISPLAY;
        end
      end
      DISPLAY: begin
        if (disp_last_c) begin
          tick_d  = '0;
          state_d = SHIFT_LO;
          if (plane_q == PLANE_W'(PLANES - 1)) begin
            plane_d = '0;
            if (row_q == ROW_W'(ROWS - 1)) begin
              row_d       = '0;
              off_d       = (off_q == COL_W'(COLS - 1)) ? '0 : off_q + COL_W'(1);
              frame_end_c = 1'b1;
              // Enable is only honoured at a frame boundary.
              if (!enable) state_d = IDLE;
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            plane_d = plane_q + PLANE_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        tick_d  = '0;
      end
    endcase
  end

  // Registered panel outputs, decoded from the current state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk       <= 1'b0;
      latch      <= 1'b0;
      blank      <= 1'b1;
      frame_done <= 1'b0;
      row_addr   <= '0;
      col_addr   <= '0;
      plane      <= '0;
      offset     <= '0;
    end else begin
      sclk       <= (state_q == SHIFT_HI);
      latch      <= (state_q == LATCH);
      blank      <= (state_q != DISPLAY);
      frame_done <= frame_end_c;
      row_addr   <= row_q;
      col_addr   <= col_q;
      plane      <= plane_q;
      offset     <= off_q;
    end
  end

endmodule

// File: doc/matrix_scan_ctrl.md
MATRIX_SCAN_CTRL -- requirements
Module: matrix_scan_ctrl

Interface
REQ-001 Parameter COLS, default 32, columns shifted per row (>=2).
REQ-002 Parameter ROWS, default 8, scan rows per frame (>=2).
REQ-003 Parameter PLANES, default 4, colour bit-planes per row (>=1).
REQ-004 Parameter DIV, default 4, clk cycles per timing phase (>=1).
REQ-005 clk  in  1  sole clock; all logic on posedge clk.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 enable  in  1  run request; sampled in IDLE and at frame end.
REQ-008 sclk  out  1  panel shift clock.
REQ-009 latch  out  1  panel data latch strobe.
REQ-010 blank  out  1  panel output disable; 1 = dark.
REQ-011 row_addr  out  $clog2(ROWS)  current scan row.
REQ-012 col_addr  out  $clog2(COLS)  column whose pixel data is being shifted.
REQ-013 plane  out  max(1,$clog2(PLANES))  current bit-plane.
REQ-014 offset  out  $clog2(COLS)  horizontal scroll offset for the pixel source.
REQ-015 frame_done  out  1  one-cycle pulse at the end of each frame.

Function
REQ-016 The FSM SHALL have states IDLE, SHIFT_LO, SHIFT_HI, BLANK, LATCH, DISPLAY, using an internal tick counter so that each SHIFT_LO, SHIFT_HI, BLANK and LATCH visit lasts exactly DIV cycles.
REQ-017 IDLE: sclk=0, latch=0, blank=1; on enable=1 go to SHIFT_LO.
REQ-018 SHIFT_LO: sclk=0; SHIFT_HI: sclk=1; blank=1 and latch=0 in both.
REQ-019 At the end of SHIFT_HI, if col_addr<COLS-1, col_addr SHALL increment and the FSM SHALL go to SHIFT_LO; otherwise col_addr SHALL wrap to 0 and the FSM SHALL go to BLANK.
REQ-020 BLANK: blank=1, sclk=0, latch=0; then LATCH.
REQ-021 LATCH: latch=1, blank=1; then DISPLAY.
REQ-022 DISPLAY: blank=0, latch=0, sclk=0, lasting DIV*2^plane cycles (see Configuration).
REQ-023 At the end of DISPLAY, plane SHALL increment.
REQ-024 When plane wraps from PLANES-1 to 0, row_addr SHALL increment.
REQ-025 When row_addr wraps from ROWS-1 to 0, offset SHALL increment modulo COLS and frame_done SHALL pulse for one cycle.
REQ-026 After DISPLAY, the next state SHALL be SHIFT_LO, except at frame end with enable=0, where it SHALL be IDLE.
REQ-027 enable deassertion mid-frame SHALL be ignored until the frame completes; no partial frame is emitted.
REQ-028 row_addr, plane and offset SHALL be stable from the first SHIFT_LO of a row/plane through its DISPLAY.
REQ-029 latch and sclk SHALL never be 1 in the same cycle.
REQ-030 blank SHALL be 1 whenever sclk or latch is 1.
REQ-031 Timing per plane: 2*COLS*DIV shift cycles, DIV blank, DIV latch, plus display time.
REQ-032 The first sclk rise SHALL occur DIV+1 cycles after the clk edge at which IDLE samples enable=1.

Reset
REQ-033 On reset assertion, state SHALL become IDLE immediately (asynchronous, any state): sclk=0, latch=0, blank=1, frame_done=0, and all counters (row_addr, col_addr, plane, offset, tick) =0.
REQ-034 After reset release, the first active edge SHALL evaluate IDLE normally.

Configuration
REQ-035 Macro MATRIX_SCAN_BCM_EN defined: DISPLAY SHALL last DIV*2^plane cycles (binary-coded modulation).
REQ-036 Macro MATRIX_SCAN_BCM_EN undefined: DISPLAY SHALL last DIV cycles for every plane; the weighting counter SHALL not be synthesised.

Verification (COLS=4, ROWS=2, PLANES=2, DIV=1 unless stated)
REQ-037 Bench SHALL check: reset, then enable=1 -> first sclk rise 2 cycles later; 4 sclk pulses with col_addr 0,1,2,3; then blank=1 for 1 cycle, latch pulse 1 cycle, blank=0 for 1 cycle.
REQ-038 Bench SHALL check: BCM_EN defined, enable held 1 -> plane 0 block = 11 cycles, plane 1 = 12, frame_done every 46 cycles, offset 0,1,2,3,0 across five frames.
REQ-039 Bench SHALL check: BCM_EN undefined -> every plane block = 11 cycles, frame_done every 44 cycles.
REQ-040 Bench SHALL check: enable dropped during row 0 -> frame completes, frame_done pulses, FSM returns to IDLE with blank=1 and no further sclk.
REQ-041 Bench SHALL check: reset pulsed asynchronously mid-LATCH -> latch=0, blank=1 and all counters 0 without waiting for a clk edge.
REQ-042 Bench SHALL check: DIV=3 -> sclk high and low phases each last 3 cycles, DISPLAY of plane 1 lasts 6 cycles; the REQ-029 and REQ-030 assertions hold throughout.
